// File: rtl/merge_pkg.sv
// Constants shared by the merge tree stages so that the run-terminator
// encoding stays identical between the input FIFOs, the merger and the output FIFO.
package merge_pkg;

    localparam int REC_DATA_W = 32;

    localparam logic [REC_DATA_W-1:0] TERM_RECORD = '0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/merge_out_fifo.sv
// Output buffer behind a two-way merger: first-word fall-through FIFO with
// early almost-full back-pressure and a count of buffered complete runs.
module merge_out_fifo
    import merge_pkg::*;
#(
    parameter int DATA_W   = REC_DATA_W,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = clog2(DEPTH),
    parameter int AF_SLACK = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_head_is_term,
    output logic [ADDR_W:0]   o_runs,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [DATA_W-1:0] TERM    = DATA_W'(TERM_RECORD);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   FULL_TH = (ADDR_W+1)'(DEPTH - AF_SLACK);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   runs_q, runs_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic rd_acc, wr_acc, term_in, term_out;

    assign o_empty        = (count_q == '0);
    assign o_full         = (count_q >= FULL_TH);
    assign o_rd_data      = o_empty ? '0 : mem_q[rd_ptr_q];
    assign o_head_is_term = ~o_empty & (o_rd_data == TERM);
    assign o_count        = count_q;
    assign o_runs         = runs_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

    always_comb begin
        rd_acc   = i_rd_en & ~o_empty;
        wr_acc   = i_wr_en & ((count_q != DEPTH_C) | rd_acc);
        term_in  = wr_acc & (i_wr_data == TERM);
        term_out = rd_acc & (o_rd_data == TERM);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        runs_d   = runs_q;
        ovf_d    = ovf_q | (i_wr_en & ~wr_acc);
        udf_d    = udf_q | (i_rd_en & o_empty);

        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({term_in, term_out})
            2'b10:   runs_d = runs_q + 1'b1;
            2'b01:   runs_d = runs_q - 1'b1;
            default: runs_d = runs_q;
        endcase

        if (i_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            runs_d   = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        runs_q   <= runs_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
    end

    // Storage is never reset; a write in the reset cycle is discarded.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) mem_q[wr_ptr_q] <= i_wr_data;
    end

endmodule

// File: tb/tb_merge_out_fifo.sv
// Directed bench for merge_out_fifo at DEPTH=8, AF_SLACK=2 with
// hand-computed expectations.
module tb_merge_out_fifo;

    localparam int DW = 32;
    localparam int DP = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [AW:0]   count;
    logic          head_term;
    logic [AW:0]   runs;
    logic          ovf;
    logic          udf;

    int n_vec = 0;
    int n_bad = 0;

    merge_out_fifo #(
        .DATA_W  (DW),
        .DEPTH   (DP),
        .ADDR_W  (AW),
        .AF_SLACK(2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (full),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_empty       (empty),
        .o_count       (count),
        .o_head_is_term(head_term),
        .o_runs        (runs),
        .o_overflow    (ovf),
        .o_underflow   (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [31:0] wd,
                       input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cyc(1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        do_rst();

        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_runs", 32'(runs), 0);
        chk("rst_hterm", 32'(head_term), 0);
        chk("rst_data", rd_data, 0);

        // Fill to almost-full threshold, then past it
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 32'(k), 1'b0);
            chk("fill_count", 32'(count), 32'(k));
            chk("fill_full", 32'(full), (k >= 6) ? 1 : 0);
        end
        cyc(1'b1, 7, 1'b0);
        cyc(1'b1, 8, 1'b0);
        chk("fill8_count", 32'(count), 8);
        chk("fill8_ovf", 32'(ovf), 0);
        cyc(1'b1, 9, 1'b0);
        chk("drop_ovf", 32'(ovf), 1);
        chk("drop_count", 32'(count), 8);
        chk("drop_head", rd_data, 1);

        // Ordering across the pointer wrap
        do_rst();
        chk("rst2_ovf", 32'(ovf), 0);
        for (int k = 10; k <= 17; k++) cyc(1'b1, 32'(k), 1'b0);
        for (int k = 10; k <= 17; k++) begin
            chk("order_a", rd_data, 32'(k));
            cyc(1'b0, 0, 1'b1);
        end
        for (int k = 20; k <= 23; k++) cyc(1'b1, 32'(k), 1'b0);
        for (int k = 20; k <= 23; k++) begin
            chk("order_b", rd_data, 32'(k));
            cyc(1'b0, 0, 1'b1);
        end
        chk("order_empty", 32'(empty), 1);

        // Simultaneous read+write while full
        for (int k = 10; k <= 17; k++) cyc(1'b1, 32'(k), 1'b0);
        chk("full_head", rd_data, 10);
        cyc(1'b1, 99, 1'b1);
        chk("rw_full_count", 32'(count), 8);
        chk("rw_full_head", rd_data, 11);
        chk("rw_full_ovf", 32'(ovf), 0);
        for (int k = 11; k <= 17; k++) begin
            chk("rw_full_seq", rd_data, 32'(k));
            cyc(1'b0, 0, 1'b1);
        end
        chk("rw_full_last", rd_data, 99);
        cyc(1'b0, 0, 1'b1);
        chk("rw_full_empty", 32'(empty), 1);

        // Simultaneous read+write while empty
        chk("pre_udf", 32'(udf), 0);
        cyc(1'b1, 5, 1'b1);
        chk("rw_empty_udf", 32'(udf), 1);
        chk("rw_empty_count", 32'(count), 1);
        chk("rw_empty_data", rd_data, 5);
        cyc(1'b0, 0, 1'b1);

        // Run tracking
        cyc(1'b1, 3, 1'b0);
        cyc(1'b1, 7, 1'b0);
        cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 2, 1'b0);
        cyc(1'b1, 0, 1'b0);
        chk("runs_2", 32'(runs), 2);
        chk("runs_hterm0", 32'(head_term), 0);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b1);
        chk("runs_hterm1", 32'(head_term), 1);
        cyc(1'b0, 0, 1'b1);
        chk("runs_1", 32'(runs), 1);
        cyc(1'b0, 0, 1'b1);
        chk("runs_term_head", 32'(head_term), 1);
        cyc(1'b1, 0, 1'b1);
        chk("runs_same", 32'(runs), 1);
        chk("runs_same_cnt", 32'(count), 1);
        chk("runs_new_term", 32'(head_term), 1);

        // Build count=5, runs=1, overflow set, then reset with a write pending
        for (int k = 1; k <= 7; k++) cyc(1'b1, 32'(k), 1'b0);
        cyc(1'b1, 9, 1'b0);
        chk("mid_ovf", 32'(ovf), 1);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        chk("mid_count", 32'(count), 5);
        chk("mid_runs", 32'(runs), 1);
        rst = 1'b1;
        cyc(1'b1, 32'h55, 1'b0);
        rst = 1'b0;
        chk("mrst_count", 32'(count), 0);
        chk("mrst_runs", 32'(runs), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_ovf", 32'(ovf), 0);
        chk("mrst_udf", 32'(udf), 0);
        chk("mrst_data", rd_data, 0);
        cyc(1'b1, 32'hAA, 1'b0);
        chk("post_count", 32'(count), 1);
        chk("post_head", rd_data, 32'hAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/merge_out_fifo.md
Name: merge_out_fifo

Overview:
- Output buffer directly downstream of the two-way merger control/datapath.
- Accepts one merged record per cycle from the merger and holds it for the next merge level or the drain port.
- Produces the merger's output-full back-pressure, early enough to cover the merger's decision latency.
- Tracks zero-valued run terminators so the consumer knows how many complete sorted runs are buffered.

Parameters:
DATA_W, 32, record width in bits; the all-zero record is the run terminator
DEPTH, 16, number of entries; must be a power of two and at least 4
ADDR_W, 4, log2(DEPTH)
AF_SLACK, 2, o_full asserts when occupancy >= DEPTH - AF_SLACK; legal range 1..DEPTH-1

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_wr_en  in  1  merger presents a record this cycle
i_wr_data  in  DATA_W  merged record
o_full  out  1  almost-full back-pressure, drives the merger's fifo_out_full
i_rd_en  in  1  consumer pops the head record
o_rd_data  out  DATA_W  head record (first-word fall-through); 0 when empty
o_empty  out  1  no entries
o_count  out  ADDR_W+1  occupancy, 0..DEPTH
o_head_is_term  out  1  head entry is a run terminator (~o_empty & head==0)
o_runs  out  ADDR_W+1  number of terminators currently stored (complete runs)
o_overflow  out  1  sticky: a write was dropped
o_underflow  out  1  sticky: a read was issued while empty

Behaviour:
Reset:
- i_rst high at a rising edge clears the read and write pointers, count, runs, overflow and underflow.
- After reset: o_empty=1, o_full=0, o_count=0, o_runs=0, o_head_is_term=0, o_rd_data=0.
- Memory contents are not cleared.
- Reset mid-operation discards all stored records in that cycle; i_wr_en and i_rd_en are ignored during the reset cycle.

Accept rules, evaluated each rising edge:
- rd_acc = i_rd_en & (count != 0).
- wr_acc = i_wr_en & ((count != DEPTH) | rd_acc).
- A read and write on the same edge when full are both accepted.
- A read and write on the same edge when empty: only the write is accepted; there is no write-through.

Pointer and count updates:
- wr_acc writes i_wr_data to mem[wr_ptr], then wr_ptr increments.
- rd_acc increments rd_ptr.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- count increments by 1 on wr_acc only, decrements by 1 on rd_acc only, and is unchanged when both are accepted.

Outputs, all registered state except these combinational decodes:
- o_empty = (count == 0).
- o_full = (count >= DEPTH - AF_SLACK).
- o_rd_data = mem[rd_ptr] when not empty, else 0.

Latency:
- A record written at edge N is visible on o_rd_data after edge N when the FIFO was empty, i.e. one-cycle write-to-read.
- o_full rises in the cycle after the write that reaches the threshold.
- Once o_full rises, the merger may still issue up to AF_SLACK writes without loss.

Run tracking:
- term_in = wr_acc & (i_wr_data == 0).
- term_out = rd_acc & (o_rd_data == 0).
- o_runs increments on term_in only, decrements on term_out only, and is unchanged when both occur.
- o_runs never exceeds count.

Error flags:
- o_overflow sets when i_wr_en & ~wr_acc.
- o_underflow sets when i_rd_en & (count == 0).
- Both flags are sticky until reset.
- A dropped write changes no other state.

Decomposition:
- Shared package (merge_pkg):
  - DATA_W default.
  - TERM_RECORD constant (all zeros).
  - clog2 helper for ADDR_W.
  - The same constants used by the merger control and the upstream input FIFOs, so terminator encoding stays identical across stages.
- Single module; the memory array stays inline as distributed RAM. No sub-module is needed.
- The same block is instantiated for each merger's A/B input FIFOs at the next tree level.

Test Plan:
- Fill/almost-full (DEPTH=8, AF_SLACK=2): after reset, write 1,2,3,4,5,6 on consecutive edges → o_full=0 through count 5, o_full=1 from the cycle after the 6th write. Writes 7 and 8 are accepted, count=8. A 9th write is dropped, o_overflow=1, count stays 8.
- Order and wrap: write 10..17, read 8, write 20..23, read 4 → read sequence is 10..17 then 20..23 across the pointer wrap; o_empty=1 at the end.
- Simultaneous full read+write: count=8 with head=10, assert rd_en and wr_en with data 99 → count stays 8, next head=11, 99 becomes the last entry, o_overflow unchanged.
- Empty boundary: count=0, assert rd_en and wr_en with data 5 → o_underflow=1, count=1, o_rd_data=5 the next cycle.
- Run tracking: write 3,7,0,2,0 → o_runs=2. Read 3 entries → o_head_is_term was 1 before the 3rd pop, o_runs=1 after it. Pop a terminator while writing 0 on the same edge → o_runs unchanged.
- Reset mid-operation: count=5, o_runs=1, overflow set, assert i_rst for one cycle with wr_en=1 → next cycle count=0, o_runs=0, o_empty=1, o_overflow=0, and the write is not stored.
